// File: rtl/ifu.sv
// Instruction fetch unit: holds the PC, fetches one word per instruction over a
// valid/ready request + valid response channel, and presents the held word with
// its PC and pre-split decode fields. Redirects are taken at retirement; fetch
// faults park the unit until reset.
module ifu #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        imem_rsp_err,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [4:0]  dec_op,
    output logic [2:0]  dec_funct3,
    output logic [1:0]  dec_funct7,
    output logic        inst_illegal,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_fault,
    output logic [31:0] fetch_cnt
);

    typedef enum logic [2:0] {
        StBoot,
        StReq,
        StWait,
        StHold,
        StFault
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] inst_pc_q, inst_pc_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] next_pc;

    // Next-state logic for the fetch sequencer and its datapath registers
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        cnt_d     = cnt_q;
        next_pc   = redirect_valid ? redirect_pc : pc_q + 32'd4;

        case (state_q)
            StBoot: state_d = StReq;
            StReq: begin
                if (imem_req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (imem_rsp_valid) begin
                    if (imem_rsp_err) begin
                        state_d = StFault;
                    end else begin
                        inst_d    = imem_rsp_data;
                        inst_pc_d = pc_q;
                        state_d   = StHold;
                    end
                end
            end
            StHold: begin
                if (inst_ready) begin
                    cnt_d = cnt_q + 32'd1;
                    // A misaligned target keeps the old PC visible for debug
                    if (next_pc[1:0] != 2'b00) begin
                        state_d = StFault;
                    end else begin
                        pc_d    = next_pc;
                        state_d = StReq;
                    end
                end
            end
            StFault: state_d = StFault;
            default: state_d = StBoot;
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StBoot;
            pc_q      <= RESET_PC;
            inst_q    <= 32'd0;
            inst_pc_q <= 32'd0;
            cnt_q     <= 32'd0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            cnt_q     <= cnt_d;
        end
    end

    // Outputs decode only registered state, so no input reaches an output
    always_comb begin
        imem_req_valid = (state_q == StReq);
        imem_req_addr  = pc_q;
        inst_valid     = (state_q == StHold);
        fetch_fault    = (state_q == StFault);
        inst           = inst_q;
        inst_pc        = inst_pc_q;
        fetch_cnt      = cnt_q;
        dec_op         = inst_q[6:2];
        dec_funct3     = inst_q[14:12];
        dec_funct7     = inst_q[30:29];
        inst_illegal   = (inst_q[1:0] != 2'b11);
    end

endmodule

// File: tb/tb_ifu.sv
// Bench for ifu: acts as instruction memory and execute stage, drives one
// instruction at a time with random stalls, and checks against a PC/count model.
module tb_ifu;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        imem_rsp_err;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [4:0]  dec_op;
    logic [2:0]  dec_funct3;
    logic [1:0]  dec_funct7;
    logic        inst_illegal;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;
    logic [31:0] fetch_cnt;

    int tests = 0;
    int fails = 0;
    int hs_cnt = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_cnt;
    logic [31:0] m_inst;
    logic [31:0] m_inst_pc;
    int          m_hs = 0;

    ifu dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .imem_rsp_err   (imem_rsp_err),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .dec_op         (dec_op),
        .dec_funct3     (dec_funct3),
        .dec_funct7     (dec_funct7),
        .inst_illegal   (inst_illegal),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .fetch_fault    (fetch_fault),
        .fetch_cnt      (fetch_cnt)
    );

    always #5 clk = ~clk;

    // Count request handshakes seen by memory
    always @(posedge clk) begin
        if (!rst && imem_req_valid && imem_req_ready) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        imem_rsp_data  = 32'd0;
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("rst_fault", {31'd0, fetch_fault}, 32'd0);
        chk("rst_inst", inst, 32'd0);
        chk("rst_inst_pc", inst_pc, 32'd0);
        chk("rst_cnt", fetch_cnt, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        m_pc      = 32'h8000_0000;
        m_cnt     = 32'd0;
        m_inst    = 32'd0;
        m_inst_pc = 32'd0;
    endtask

    // One instruction: request (rs stalls), response (rd delay), hold (hstall)
    task automatic fetch_one(input int rs, input int rd, input int hstall, input bit redir,
                             input logic [31:0] rpc, input logic [31:0] data, input bit err,
                             input bit frc);
        logic [31:0] nxt;
        chk("req_valid", {31'd0, imem_req_valid}, 32'd1);
        chk("req_addr", imem_req_addr, m_pc);
        chk("req_no_inst", {31'd0, inst_valid}, 32'd0);
        for (int i = 0; i < rs; i++) begin
            imem_req_ready = 1'b0;
            imem_rsp_valid = 1'b1;
            imem_rsp_err   = 1'($urandom);
            imem_rsp_data  = $urandom;
            @(negedge clk);
            chk("req_stall_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("req_stall_addr", imem_req_addr, m_pc);
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        m_hs++;
        chk("wait_no_req", {31'd0, imem_req_valid}, 32'd0);
        chk("wait_no_inst", {31'd0, inst_valid}, 32'd0);
        chk("hs_count", hs_cnt, m_hs);
        for (int i = 0; i < rd; i++) begin
            imem_rsp_data = $urandom;
            @(negedge clk);
            chk("wait_delay_inst", {31'd0, inst_valid}, 32'd0);
            chk("wait_delay_req", {31'd0, imem_req_valid}, 32'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        imem_rsp_err   = err;
        @(negedge clk);
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        if (err) begin
            chk("err_fault", {31'd0, fetch_fault}, 32'd1);
            chk("err_no_inst", {31'd0, inst_valid}, 32'd0);
            chk("err_no_req", {31'd0, imem_req_valid}, 32'd0);
            chk("err_inst_kept", inst, m_inst);
            chk("err_inst_pc_kept", inst_pc, m_inst_pc);
            return;
        end
        m_inst    = data;
        m_inst_pc = m_pc;
        chk("hold_valid", {31'd0, inst_valid}, 32'd1);
        chk("hold_inst", inst, m_inst);
        chk("hold_inst_pc", inst_pc, m_inst_pc);
        chk("dec_op", {27'd0, dec_op}, {27'd0, data[6:2]});
        chk("dec_funct3", {29'd0, dec_funct3}, {29'd0, data[14:12]});
        chk("dec_funct7", {30'd0, dec_funct7}, {30'd0, data[30:29]});
        chk("illegal", {31'd0, inst_illegal}, {31'd0, data[1:0] != 2'b11});
        chk("hold_cnt", fetch_cnt, m_cnt);
        if (frc) begin
            force dut.cnt_q = 32'hFFFF_FFFF;
            @(negedge clk);
            release dut.cnt_q;
            m_cnt = 32'hFFFF_FFFF;
            chk("forced_cnt", fetch_cnt, m_cnt);
        end
        for (int i = 0; i < hstall; i++) begin
            inst_ready     = 1'b0;
            redirect_valid = 1'($urandom);
            redirect_pc    = 32'h8000_0002;
            imem_rsp_valid = 1'b1;
            imem_rsp_err   = 1'b1;
            @(negedge clk);
            chk("hold_stall_valid", {31'd0, inst_valid}, 32'd1);
            chk("hold_stall_inst", inst, m_inst);
            chk("hold_stall_cnt", fetch_cnt, m_cnt);
            chk("hold_stall_fault", {31'd0, fetch_fault}, 32'd0);
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_err   = 1'b0;
        inst_ready     = 1'b1;
        redirect_valid = redir;
        redirect_pc    = rpc;
        @(negedge clk);
        inst_ready     = 1'b0;
        redirect_valid = 1'b0;
        m_cnt = m_cnt + 32'd1;
        nxt   = redir ? rpc : m_pc + 32'd4;
        chk("retire_cnt", fetch_cnt, m_cnt);
        if (nxt[1:0] != 2'b00) begin
            chk("misalign_fault", {31'd0, fetch_fault}, 32'd1);
            chk("misalign_no_req", {31'd0, imem_req_valid}, 32'd0);
            chk("misalign_no_inst", {31'd0, inst_valid}, 32'd0);
            chk("misalign_pc_kept", imem_req_addr, m_pc);
        end else begin
            m_pc = nxt;
            chk("next_req_valid", {31'd0, imem_req_valid}, 32'd1);
            chk("next_req_addr", imem_req_addr, m_pc);
            chk("next_no_inst", {31'd0, inst_valid}, 32'd0);
        end
    endtask

    // Parked in FAULT: no requests even with memory ready
    task automatic idle_fault(input int n);
        for (int i = 0; i < n; i++) begin
            imem_req_ready = 1'b1;
            imem_rsp_valid = 1'($urandom);
            @(negedge clk);
            chk("fault_sticky", {31'd0, fetch_fault}, 32'd1);
            chk("fault_no_req", {31'd0, imem_req_valid}, 32'd0);
            chk("fault_no_inst", {31'd0, inst_valid}, 32'd0);
            chk("fault_hs", hs_cnt, m_hs);
        end
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
    endtask

    initial begin
        // Reset and boot, then sra decode with zero stalls
        do_reset();
        fetch_one(0, 0, 0, 1'b0, 32'd0, 32'h4000_D0B3, 1'b0, 1'b0);
        chk("sra_op", {27'd0, dec_op}, 32'b01100);
        chk("sra_funct3", {29'd0, dec_funct3}, 32'b101);
        chk("sra_funct7", {30'd0, dec_funct7}, 32'b10);
        chk("sra_legal", {31'd0, inst_illegal}, 32'd0);
        chk("boot_next_addr", imem_req_addr, 32'h8000_0004);
        chk("boot_cnt", fetch_cnt, 32'd1);

        // Backpressure on all three channels
        fetch_one(3, 2, 4, 1'b0, 32'd0, 32'h0000_0013, 1'b0, 1'b0);
        // Illegal encoding
        fetch_one(0, 0, 0, 1'b0, 32'd0, 32'h0000_0001, 1'b0, 1'b0);
        // Redirect, with stray redirects during the hold stall
        fetch_one(0, 0, 2, 1'b1, 32'h8000_0100, 32'h0000_006F, 1'b0, 1'b0);
        chk("redirect_addr", imem_req_addr, 32'h8000_0100);
        // PC wraps from the top of the address space
        fetch_one(1, 1, 1, 1'b1, 32'hFFFF_FFFC, 32'h0000_0067, 1'b0, 1'b0);
        fetch_one(0, 0, 0, 1'b0, 32'd0, 32'h0000_0033, 1'b0, 1'b0);
        chk("pc_wrap_addr", imem_req_addr, 32'd0);
        // Counter wrap
        fetch_one(0, 0, 1, 1'b1, 32'h8000_0000, 32'h0000_0033, 1'b0, 1'b1);
        chk("cnt_wrap", fetch_cnt, 32'd0);

        // Random traffic
        for (int k = 0; k < 40; k++) begin
            fetch_one(int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                      int'($urandom_range(0, 3)), 1'($urandom),
                      32'h8000_0000 + ($urandom_range(0, 255) << 2), $urandom, 1'b0, 1'b0);
        end

        // Misaligned redirect faults
        fetch_one(0, 0, 0, 1'b1, 32'h8000_0102, 32'h0000_0063, 1'b0, 1'b0);
        idle_fault(5);

        // Response error faults without ever presenting an instruction
        do_reset();
        fetch_one(1, 1, 0, 1'b0, 32'd0, 32'h0000_0013, 1'b1, 1'b0);
        idle_fault(4);

        // Async reset in WAIT, then a stale response must be ignored
        do_reset();
        fetch_one(0, 0, 0, 1'b0, 32'd0, 32'h1234_5673, 1'b0, 1'b0);
        imem_req_ready = 1'b1;
        @(negedge clk);
        imem_req_ready = 1'b0;
        m_hs++;
        #2 rst = 1'b1;
        #1;
        chk("async_req_valid", {31'd0, imem_req_valid}, 32'd0);
        chk("async_inst_valid", {31'd0, inst_valid}, 32'd0);
        chk("async_inst", inst, 32'd0);
        chk("async_inst_pc", inst_pc, 32'd0);
        chk("async_cnt", fetch_cnt, 32'd0);
        chk("async_addr", imem_req_addr, 32'h8000_0000);
        @(negedge clk);
        rst            = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stale_no_inst", {31'd0, inst_valid}, 32'd0);
            chk("stale_inst", inst, 32'd0);
            chk("stale_req", {31'd0, imem_req_valid}, 32'd1);
        end
        imem_rsp_valid = 1'b0;
        m_pc      = 32'h8000_0000;
        m_cnt     = 32'd0;
        m_inst    = 32'd0;
        m_inst_pc = 32'd0;
        fetch_one(0, 1, 1, 1'b0, 32'd0, 32'h0000_0093, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
